// File: rtl/dl_router.sv
// dl_router: steers the hps_io ioctl byte stream to one of NUM_TARGETS destinations,
// packs bytes little-endian into DATA_W-bit words with byte enables and hands them
// over a per-target valid/ack handshake while holding the selected target in reset.
module dl_router #(
    parameter int unsigned NUM_TARGETS = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned INDEX_W     = 8,
    localparam int unsigned BYTES      = DATA_W / 8,
    localparam int unsigned LB         = $clog2(BYTES)
) (
    input  logic                   clk_sys_i,
    input  logic                   reset_i,
    input  logic                   ioctl_download_i,
    input  logic                   ioctl_wr_i,
    input  logic [ADDR_W-1:0]      ioctl_addr_i,
    input  logic [7:0]             ioctl_dout_i,
    input  logic [INDEX_W-1:0]     ioctl_index_i,
    output logic                   ioctl_wait_o,
    output logic [NUM_TARGETS-1:0] tgt_wr_o,
    output logic [ADDR_W-LB-1:0]   tgt_addr_o,
    output logic [DATA_W-1:0]      tgt_data_o,
    output logic [BYTES-1:0]       tgt_be_o,
    input  logic [NUM_TARGETS-1:0] tgt_ack_i,
    output logic [NUM_TARGETS-1:0] tgt_hold_o,
    output logic                   dn_done_o,
    output logic [ADDR_W:0]        dn_bytes_o,
    output logic                   dn_err_o
);

    localparam int unsigned TgtW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int unsigned LbW  = (LB > 0) ? LB : 1;
    localparam int unsigned WaW  = ADDR_W - LB;

    typedef enum logic [1:0] {StIdle, StActive, StFlush, StDone} state_e;

    state_e              state_q, state_d;
    logic                dl_prev_q, dl_prev_d;
    logic [TgtW-1:0]     tgt_q, tgt_d;
    logic                disc_q, disc_d;
    logic                hold_q, hold_d;
    logic [WaW-1:0]      acc_waddr_q, acc_waddr_d;
    logic [DATA_W-1:0]   acc_data_q, acc_data_d;
    logic [BYTES-1:0]    acc_be_q, acc_be_d;
    logic                acc_valid_q, acc_valid_d;
    logic                acc_go_q, acc_go_d;   // accumulator completed but output was busy
    logic [WaW-1:0]      out_waddr_q, out_waddr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [BYTES-1:0]    out_be_q, out_be_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W:0]     dn_bytes_q, dn_bytes_d;
    logic                dn_err_q, dn_err_d;

    logic [LbW-1:0]      lane;
    logic [WaW-1:0]      waddr;
    logic                start_edge, accept, drop, same, ack_sel;
    logic                move_acc, move_new, load_new, lane_top;
    logic [DATA_W-1:0]   mrg_data;
    logic [BYTES-1:0]    mrg_be;

    if (LB > 0) begin : g_lane
        assign lane = ioctl_addr_i[LbW-1:0];
    end else begin : g_nolane
        assign lane = '0;
    end
    assign waddr = ioctl_addr_i[ADDR_W-1:LB];

    // Output decode from registered state
    always_comb begin
        tgt_wr_o   = '0;
        tgt_hold_o = '0;
        for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
            tgt_wr_o[t]   = out_valid_q && (tgt_q == TgtW'(t));
            tgt_hold_o[t] = hold_q && (tgt_q == TgtW'(t));
        end
    end

    assign ioctl_wait_o = out_valid_q || (state_q == StFlush) || (state_q == StDone);
    assign tgt_addr_o   = out_waddr_q;
    assign tgt_data_o   = out_data_q;
    assign tgt_be_o     = out_be_q;
    assign dn_done_o    = (state_q == StDone);
    assign dn_bytes_o   = dn_bytes_q;
    assign dn_err_o     = dn_err_q;

    assign start_edge = ioctl_download_i && !dl_prev_q;
    assign accept     = (state_q == StActive) && ioctl_wr_i && !ioctl_wait_o;
    assign drop       = (state_q == StActive) && ioctl_wr_i && ioctl_wait_o;
    assign same       = acc_valid_q && (acc_waddr_q == waddr);
    assign ack_sel    = |(tgt_ack_i & tgt_wr_o);
    assign lane_top   = (lane == LbW'(BYTES - 1));

    // Next-state: FSM, accumulator packing, output register and counters
    always_comb begin
        state_d     = state_q;
        dl_prev_d   = ioctl_download_i;
        tgt_d       = tgt_q;
        disc_d      = disc_q;
        hold_d      = hold_q;
        acc_waddr_d = acc_waddr_q;
        acc_data_d  = acc_data_q;
        acc_be_d    = acc_be_q;
        acc_valid_d = acc_valid_q;
        acc_go_d    = acc_go_q;
        out_waddr_d = out_waddr_q;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        out_valid_d = out_valid_q;
        dn_bytes_d  = dn_bytes_q;
        dn_err_d    = dn_err_q;
        move_acc    = 1'b0;
        move_new    = 1'b0;
        load_new    = 1'b0;

        mrg_data = same ? acc_data_q : '0;
        mrg_be   = same ? acc_be_q : '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (LbW'(b) == lane) begin
                mrg_data[b*8 +: 8] = ioctl_dout_i;
                mrg_be[b]          = 1'b1;
            end
        end

        if (out_valid_q && ack_sel) out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StActive;
                    tgt_d      = ioctl_index_i[TgtW-1:0];
                    disc_d     = (32'(ioctl_index_i) >= NUM_TARGETS);
                    dn_err_d   = (32'(ioctl_index_i) >= NUM_TARGETS);
                    hold_d     = !(32'(ioctl_index_i) >= NUM_TARGETS);
                    dn_bytes_d = '0;
                end
            end
            StActive: begin
                if (!ioctl_download_i) state_d = StFlush;
            end
            StFlush: begin
                if (!acc_valid_q && !out_valid_q) state_d = StDone;
                else if (acc_valid_q && !out_valid_q) move_acc = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
                hold_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (drop) dn_err_d = 1'b1;

        if (accept) begin
            if (dn_bytes_q != '1) dn_bytes_d = dn_bytes_q + 1'b1;
            if (!disc_q) begin
                // Output is free here since ioctl_wait was low
                if (acc_valid_q && !same) move_acc = 1'b1;
                if ((lane_top || (same && acc_go_q)) && !move_acc) move_new = 1'b1;
                else load_new = 1'b1;
            end
        end else if ((state_q == StActive) && acc_valid_q && acc_go_q && !out_valid_q) begin
            move_acc = 1'b1;
        end

        if (move_acc) begin
            out_waddr_d = acc_waddr_q;
            out_data_d  = acc_data_q;
            out_be_d    = acc_be_q;
            out_valid_d = 1'b1;
            acc_valid_d = 1'b0;
            acc_go_d    = 1'b0;
        end
        if (move_new) begin
            out_waddr_d = waddr;
            out_data_d  = mrg_data;
            out_be_d    = mrg_be;
            out_valid_d = 1'b1;
            acc_valid_d = 1'b0;
            acc_go_d    = 1'b0;
        end
        if (load_new) begin
            acc_waddr_d = waddr;
            acc_data_d  = mrg_data;
            acc_be_d    = mrg_be;
            acc_valid_d = 1'b1;
            acc_go_d    = lane_top;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            dl_prev_q   <= 1'b0;
            tgt_q       <= '0;
            disc_q      <= 1'b0;
            hold_q      <= 1'b0;
            acc_waddr_q <= '0;
            acc_data_q  <= '0;
            acc_be_q    <= '0;
            acc_valid_q <= 1'b0;
            acc_go_q    <= 1'b0;
            out_waddr_q <= '0;
            out_data_q  <= '0;
            out_be_q    <= '0;
            out_valid_q <= 1'b0;
            dn_bytes_q  <= '0;
            dn_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_prev_q   <= dl_prev_d;
            tgt_q       <= tgt_d;
            disc_q      <= disc_d;
            hold_q      <= hold_d;
            acc_waddr_q <= acc_waddr_d;
            acc_data_q  <= acc_data_d;
            acc_be_q    <= acc_be_d;
            acc_valid_q <= acc_valid_d;
            acc_go_q    <= acc_go_d;
            out_waddr_q <= out_waddr_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
            out_valid_q <= out_valid_d;
            dn_bytes_q  <= dn_bytes_d;
            dn_err_q    <= dn_err_d;
        end
    end

endmodule

// File: tb/tb_dl_router.sv
// Bench for dl_router (DATA_W=32, two targets): table of downloads plus hand-written
// stall and reset sequences; output words are checked against a scoreboard queue.
module tb_dl_router;

    logic        clk = 1'b0;
    logic        reset, dl, wr, wait_s, done, err, ack_en;
    logic [15:0] addr;
    logic [7:0]  dout, idx;
    logic [1:0]  tgt_wr, ack, hold;
    logic [13:0] taddr;
    logic [31:0] tdata;
    logic [3:0]  tbe;
    logic [16:0] dbytes;

    always #5 clk = ~clk;
    assign ack = ack_en ? 2'b11 : 2'b00;

    dl_router #(.NUM_TARGETS(2), .ADDR_W(16), .DATA_W(32), .INDEX_W(8)) dut (
        .clk_sys_i(clk), .reset_i(reset), .ioctl_download_i(dl), .ioctl_wr_i(wr),
        .ioctl_addr_i(addr), .ioctl_dout_i(dout), .ioctl_index_i(idx), .ioctl_wait_o(wait_s),
        .tgt_wr_o(tgt_wr), .tgt_addr_o(taddr), .tgt_data_o(tdata), .tgt_be_o(tbe),
        .tgt_ack_i(ack), .tgt_hold_o(hold), .dn_done_o(done), .dn_bytes_o(dbytes),
        .dn_err_o(err)
    );

    typedef struct packed {
        logic [1:0]  tgt;
        logic [13:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } word_t;

    typedef struct packed {
        logic [7:0]        idx;
        logic [2:0]        nb;
        logic [5:0][15:0]  addr;
        logic [5:0][7:0]   data;
        logic [1:0]        nw;
        logic [1:0][13:0]  waddr;
        logic [1:0][31:0]  wdata;
        logic [1:0][3:0]   wbe;
        logic [16:0]       exp_bytes;
        logic              exp_err;
        logic [1:0]        exp_hold;
    } vec_t;

    word_t sb[$];
    vec_t  vecs[4];
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: compare each handed-over word against the oldest expectation
    always @(negedge clk) begin : mon
        word_t e;
        logic [31:0] m;
        if ((tgt_wr & ack) != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(tgt_wr), 64'(2'b00));
            end else begin
                e = sb.pop_front();
                m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                check("word_tgt", 64'(tgt_wr), 64'(e.tgt));
                check("word_addr", 64'(taddr), 64'(e.waddr));
                check("word_be", 64'(tbe), 64'(e.be));
                check("word_data", 64'(tdata & m), 64'(e.data & m));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] ix);
        idx = ix;
        dl  = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        while (wait_s && n < 20) begin
            tick();
            n++;
        end
        if (wait_s) check("wait_timeout", 64'(wait_s), 64'(1'b0));
        addr = a;
        dout = d;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
    endtask

    task automatic finish_dl(input logic [1:0] exp_hold, input logic [16:0] exp_bytes,
                             input logic exp_err, input string tag);
        int n = 0;
        dl = 1'b0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'(1'b1));
        check({tag, "_hold_at_done"}, 64'(hold), 64'(exp_hold));
        check({tag, "_bytes"}, 64'(dbytes), 64'(exp_bytes));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'(1'b0));
        check({tag, "_hold_released"}, 64'(hold), 64'(2'b00));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        word_t w;
        logic [1:0] oh;
        ack_en = 1'b1;
        oh = (v.idx == 8'd0) ? 2'b01 : (v.idx == 8'd1) ? 2'b10 : 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (i < int'(v.nw)) begin
                w.tgt   = oh;
                w.waddr = v.waddr[i];
                w.data  = v.wdata[i];
                w.be    = v.wbe[i];
                sb.push_back(w);
            end
        end
        start_dl(v.idx);
        check({tag, "_hold_start"}, 64'(hold), 64'(v.exp_hold));
        check({tag, "_bytes_cleared"}, 64'(dbytes), 64'(0));
        check({tag, "_err_start"}, 64'(err), 64'(v.exp_err));
        for (int i = 0; i < 6; i++) begin
            if (i < int'(v.nb)) send_byte(v.addr[i], v.data[i]);
        end
        finish_dl(v.exp_hold, v.exp_bytes, v.exp_err, tag);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        word_t w;
        reset = 1'b1; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0; idx = '0; ack_en = 1'b1;

        // Vector table: inputs and expected words / status
        for (int k = 0; k < 4; k++) begin
            vecs[k] = '0;
            for (int i = 0; i < 6; i++) vecs[k].addr[i] = 16'(i);
        end
        vecs[0].idx = 8'd0; vecs[0].nb = 3'd4;
        vecs[0].data = {8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        vecs[0].nw = 2'd1; vecs[0].waddr[0] = 14'd0; vecs[0].wdata[0] = 32'h44332211;
        vecs[0].wbe[0] = 4'hf; vecs[0].exp_bytes = 17'd4; vecs[0].exp_hold = 2'b01;

        vecs[1].idx = 8'd0; vecs[1].nb = 3'd6;
        vecs[1].data = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        vecs[1].nw = 2'd2;
        vecs[1].waddr[0] = 14'd0; vecs[1].wdata[0] = 32'h44332211; vecs[1].wbe[0] = 4'hf;
        vecs[1].waddr[1] = 14'd1; vecs[1].wdata[1] = 32'h00006655; vecs[1].wbe[1] = 4'h3;
        vecs[1].exp_bytes = 17'd6; vecs[1].exp_hold = 2'b01;

        vecs[2].idx = 8'd1; vecs[2].nb = 3'd2;
        vecs[2].addr[1] = 16'd8; vecs[2].data[0] = 8'h5a; vecs[2].data[1] = 8'ha5;
        vecs[2].nw = 2'd2;
        vecs[2].waddr[0] = 14'd0; vecs[2].wdata[0] = 32'h0000005a; vecs[2].wbe[0] = 4'h1;
        vecs[2].waddr[1] = 14'd2; vecs[2].wdata[1] = 32'h000000a5; vecs[2].wbe[1] = 4'h1;
        vecs[2].exp_bytes = 17'd2; vecs[2].exp_hold = 2'b10;

        vecs[3].idx = 8'd7; vecs[3].nb = 3'd3;
        vecs[3].data = {8'h00, 8'h00, 8'h00, 8'h03, 8'h02, 8'h01};
        vecs[3].exp_bytes = 17'd3; vecs[3].exp_err = 1'b1; vecs[3].exp_hold = 2'b00;

        repeat (3) tick();
        check("rst_tgt_wr", 64'(tgt_wr), 64'(2'b00));
        check("rst_hold", 64'(hold), 64'(2'b00));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_bytes", 64'(dbytes), 64'(0));
        check("rst_err", 64'(err), 64'(1'b0));
        check("rst_wait", 64'(wait_s), 64'(1'b0));
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Back-pressure: ack held low, forced write during the stall is dropped
        ack_en = 1'b0;
        w.tgt = 2'b10; w.waddr = 14'd0; w.data = 32'hd4c3b2a1; w.be = 4'hf;
        sb.push_back(w);
        start_dl(8'd1);
        send_byte(16'd0, 8'ha1);
        send_byte(16'd1, 8'hb2);
        send_byte(16'd2, 8'hc3);
        send_byte(16'd3, 8'hd4);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) wr = 1'b0;
            check("stall_wr", 64'(tgt_wr), 64'(2'b10));
            check("stall_data", 64'(tdata), 64'(32'hd4c3b2a1));
            check("stall_wait", 64'(wait_s), 64'(1'b1));
            if (k == 2) begin
                addr = 16'd4; dout = 8'hee; wr = 1'b1;
            end
            tick();
        end
        check("stall_err", 64'(err), 64'(1'b1));
        ack_en = 1'b1;
        tick();
        check("stall_released_wr", 64'(tgt_wr), 64'(2'b00));
        check("stall_released_wait", 64'(wait_s), 64'(1'b0));
        finish_dl(2'b10, 17'd4, 1'b1, "stall");

        // Reset with an unacknowledged word pending
        ack_en = 1'b0;
        start_dl(8'd0);
        send_byte(16'd0, 8'h11);
        send_byte(16'd1, 8'h22);
        send_byte(16'd2, 8'h33);
        send_byte(16'd3, 8'h44);
        check("rst_mid_pending", 64'(tgt_wr), 64'(2'b01));
        reset = 1'b1;
        dl    = 1'b0;
        tick();
        check("rst_mid_wr", 64'(tgt_wr), 64'(2'b00));
        check("rst_mid_hold", 64'(hold), 64'(2'b00));
        check("rst_mid_wait", 64'(wait_s), 64'(1'b0));
        check("rst_mid_bytes", 64'(dbytes), 64'(0));
        reset  = 1'b0;
        ack_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_mid_no_done", 64'(done), 64'(1'b0));
        end
        run_vec(vecs[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
